// File: rtl/mxacc_host_sequencer.sv
// Host-side job sequencer for the matrix accelerator: streams in A rows and B,
// holds operands/config while the accelerator runs, and returns the captured result.
module mxacc_host_sequencer #(
    parameter int ROWS           = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_BITS        = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [263:0]        in_data,
    input  logic                cfg_int8,
    input  logic                cfg_int4,
    input  logic                cfg_vsq,
    input  logic [7:0]          cfg_scale,
    input  logic [7:0]          cfg_bias,
    output logic [ROWS*264-1:0] a_vec,
    output logic [263:0]        b_vec,
    output logic                is_int8_mode,
    output logic                is_int4_mode,
    output logic                is_vsq,
    output logic [7:0]          scale,
    output logic [7:0]          bias,
    output logic                valid_mac,
    output logic                valid_ppu,
    input  logic                acc_done,
    input  logic [127:0]        acc_softmax,
    input  logic [135:0]        acc_quant,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [127:0]        res_softmax,
    output logic [135:0]        res_quant,
    output logic                res_err,
    output logic                busy
);

    localparam int BW      = 264;
    localparam int BC_BITS = $clog2(ROWS + 1);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT, OUT} state_t;

    state_t               state_reg;
    logic [BC_BITS-1:0]   beat_cnt_reg;
    logic [TO_BITS-1:0]   to_cnt_reg;
    logic [BW-1:0]        a_rows_reg [ROWS];
    logic [ROWS-1:0]      row_we;
    logic                 xfer;
    logic                 done_q;
    logic                 to_last;

    assign in_ready = (state_reg == IDLE) || (state_reg == LOAD_A) || (state_reg == LOAD_B);
    assign busy     = (state_reg != IDLE);
    assign xfer     = in_valid && in_ready;
    // The first two WAIT cycles may still see done from the previous job.
    assign done_q   = (state_reg == WAIT) && acc_done && (to_cnt_reg >= TO_BITS'(2));
    assign to_last  = (to_cnt_reg == TO_BITS'(TIMEOUT_CYCLES - 1));

    // Beat count is zero in IDLE, so one decode covers the first row and the rest.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            assign row_we[gi] = xfer && ((state_reg == IDLE) || (state_reg == LOAD_A))
                                && (beat_cnt_reg == BC_BITS'(gi));
            assign a_vec[gi*BW +: BW] = a_rows_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                a_rows_reg[r] <= '0;
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_we[r]) begin
                    a_rows_reg[r] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            to_cnt_reg   <= '0;
            b_vec        <= '0;
            is_int8_mode <= 1'b0;
            is_int4_mode <= 1'b0;
            is_vsq       <= 1'b0;
            scale        <= '0;
            bias         <= '0;
            valid_mac    <= 1'b0;
            valid_ppu    <= 1'b0;
            res_valid    <= 1'b0;
            res_softmax  <= '0;
            res_quant    <= '0;
            res_err      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (xfer) begin
                        is_int8_mode <= cfg_int8;
                        is_int4_mode <= cfg_int4;
                        is_vsq       <= cfg_vsq;
                        scale        <= cfg_scale;
                        bias         <= cfg_bias;
                        beat_cnt_reg <= BC_BITS'(1);
                        state_reg    <= (ROWS == 1) ? LOAD_B : LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (xfer) begin
                        beat_cnt_reg <= beat_cnt_reg + BC_BITS'(1);
                        if (beat_cnt_reg == BC_BITS'(ROWS - 1)) begin
                            state_reg <= LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        b_vec      <= in_data;
                        valid_mac  <= 1'b1;
                        valid_ppu  <= 1'b1;
                        to_cnt_reg <= '0;
                        state_reg  <= WAIT;
                    end
                end
                WAIT: begin
                    // A qualified done beats a simultaneous timeout.
                    if (done_q) begin
                        res_softmax <= acc_softmax;
                        res_quant   <= acc_quant;
                        res_err     <= 1'b0;
                        valid_mac   <= 1'b0;
                        valid_ppu   <= 1'b0;
                        res_valid   <= 1'b1;
                        state_reg   <= OUT;
                    end else if (to_last) begin
                        res_softmax <= '0;
                        res_quant   <= '0;
                        res_err     <= 1'b1;
                        valid_mac   <= 1'b0;
                        valid_ppu   <= 1'b0;
                        res_valid   <= 1'b1;
                        state_reg   <= OUT;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_BITS'(1);
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid    <= 1'b0;
                        beat_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mxacc_host_sequencer.md
Name: mxacc_host_sequencer

Overview:
- Host-side sequencer that drives the matrix accelerator from the opposite side of its operand/result interface.
- Accepts operand rows as a stream of 264-bit beats over a valid/ready handshake and assembles the 4224-bit A matrix and the 264-bit B vector.
- Holds the accelerator mode and PPU configuration stable, raises the MAC/PPU valids, and waits for the accelerator done.
- Captures the softmax and quantized results and returns them to the host over a second valid/ready handshake. Reports an error on timeout.

Parameters:
- ROWS, 16, number of A rows (beats) per job; a_vec width = ROWS*264.
- TIMEOUT_CYCLES, 4096, maximum WAIT cycles before the job is aborted with an error.
- TO_BITS, 13, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  host operand beat valid.
- in_ready  out  1  sequencer can accept a beat.
- in_data  in  264  operand beat (A row, or B on the final beat).
- cfg_int8  in  1  mode bit; sampled on the first accepted beat of a job.
- cfg_int4  in  1  mode bit; sampled on the first accepted beat of a job.
- cfg_vsq  in  1  mode bit; sampled on the first accepted beat of a job.
- cfg_scale  in  8  PPU scale; sampled on the first accepted beat.
- cfg_bias  in  8  PPU bias; sampled on the first accepted beat.
- a_vec  out  ROWS*264  to accelerator.
- b_vec  out  264  to accelerator.
- is_int8_mode  out  1  to accelerator.
- is_int4_mode  out  1  to accelerator.
- is_vsq  out  1  to accelerator.
- scale  out  8  to accelerator.
- bias  out  8  to accelerator.
- valid_mac  out  1  to accelerator.
- valid_ppu  out  1  to accelerator.
- acc_done  in  1  accelerator done.
- acc_softmax  in  128  accelerator softmax result.
- acc_quant  in  136  accelerator quantized result.
- res_valid  out  1  result available to host.
- res_ready  in  1  host accepts the result.
- res_softmax  out  128  captured softmax result.
- res_quant  out  136  captured quantized result.
- res_err  out  1  result is from a timed-out job.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including a_vec, b_vec, config outputs and result registers.
  - Beat and timeout counters clear.
  - Reset in any state aborts the job; no partial result is emitted.
- States: IDLE, LOAD_A, LOAD_B, WAIT, OUT.
- in_ready is 1 in IDLE, LOAD_A and LOAD_B, and 0 otherwise. A beat transfers when in_valid && in_ready.
- IDLE:
  - On a transfer, latch the cfg_* inputs into the mode/scale/bias outputs.
  - Write in_data into row 0, i.e. a_vec[263:0]. Set beat count to 1.
  - Go to LOAD_A, or to LOAD_B if ROWS=1.
- LOAD_A:
  - Beat k goes to a_vec[264k+263:264k].
  - After the transfer of beat ROWS-1, go to LOAD_B.
  - cfg_* inputs are ignored after the first beat.
- LOAD_B:
  - The transfer writes b_vec.
  - Next cycle: state WAIT, valid_mac=1, valid_ppu=1, both registered. Timeout counter clears.
- WAIT:
  - valid_mac and valid_ppu stay high.
  - a_vec, b_vec, mode, scale and bias are held constant.
  - acc_done is ignored during the first 2 WAIT cycles, to mask stale done from a previous job. After that it is qualified.
  - Qualified acc_done=1:
    - Capture acc_softmax into res_softmax and acc_quant into res_quant, and set res_err=0, all at that edge.
    - Next cycle: valid_mac=valid_ppu=0, res_valid=1, state OUT.
  - Timeout counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES-1 with no qualified done:
    - res_softmax=0, res_quant=0, res_err=1.
    - valid_mac=valid_ppu=0, go to OUT.
  - If done and timeout occur in the same cycle, done wins and res_err=0.
- OUT:
  - res_valid=1. Result outputs are stable until the handshake.
  - On res_valid && res_ready: next cycle res_valid=0, state IDLE, in_ready=1.
  - The result registers keep their last value until overwritten.
- Latency:
  - From the final beat transfer to valid_mac=1: 1 cycle.
  - From qualified acc_done to res_valid=1: 1 cycle.
  - Minimum job length: ROWS+1 beat cycles + 3 WAIT cycles + 1 OUT cycle.
- Beats presented outside IDLE/LOAD_A/LOAD_B are not accepted (in_ready=0). The host holds in_valid and in_data until the transfer.
- The beat counter is ceil(log2(ROWS+1)) bits and clears on entry to IDLE.

Test Plan:
- Basic job:
  - Stimulus: 17 back-to-back beats, row k = {33{8'(k+1)}}, B = {33{8'hAA}}, cfg_int8=1, scale=8'h10, bias=8'h02. Model asserts acc_done 20 cycles after valid_mac rises, softmax=128'h0123…, quant=136'hFF….
  - Required: a_vec row 5 = {33{8'h06}}; valid_mac rises 1 cycle after beat 17; res_valid 1 cycle after done with the exact captured values; res_err=0.
- Input backpressure gaps:
  - Stimulus: in_valid toggles 1/0 every cycle.
  - Required: identical a_vec/b_vec to the basic job; cfg changes after beat 1 do not affect is_int8_mode/scale.
- Stale done:
  - Stimulus: acc_done held 1 entering WAIT for 2 cycles, then 0, then pulsed at WAIT cycle 10.
  - Required: capture only at cycle 10.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=64, acc_done never asserted.
  - Required: at WAIT cycle 63, valid_mac falls; res_valid=1, res_err=1, results 0.
  - Then a second job completes normally with res_err=0.
- Output backpressure:
  - Stimulus: res_ready=0 for 10 cycles.
  - Required: res_* stable, in_ready=0, busy=1; one cycle after res_ready=1, in_ready=1 and busy=0.
- Reset mid-operation:
  - Stimulus: rst_n=0 for 1 cycle at LOAD_A beat 7, then at WAIT cycle 5.
  - Required: all outputs 0, state IDLE, no res_valid; a subsequent full job is correct.
